// File: rtl/write_buffer.sv
// Posted-store write buffer: a circular queue drained one command at a time to memory.
// Entries retire only when memory signals completion; pending loads can probe for word overlap.
module write_buffer #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        write,
  input  logic [2:0]  length,
  input  logic [31:0] addr,
  input  logic [31:0] data,
  output logic        busy,
  input  logic [31:0] query_addr,
  output logic        hazard,
  output logic        empty,
  output logic        overflow,
  input  logic        mem_busy,
  input  logic        mem_done,
  output logic        mem_write,
  output logic [2:0]  mem_length,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_data
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

  state_e          state_q, state_d;
  logic [PtrW-1:0] head_q, head_d;
  logic [PtrW-1:0] tail_q, tail_d;
  logic [CntW-1:0] count_q, count_d;
  logic            overflow_q, overflow_d;
  logic            mem_write_q, mem_write_d;

  logic [2:0]  len_mem  [DEPTH];
  logic [31:0] addr_mem [DEPTH];
  logic [31:0] data_mem [DEPTH];

  logic full, enq, ret;

  assign full = (count_q == CntW'(DEPTH));
  assign enq  = write && !full;
  assign ret  = (state_q == StWait) && mem_done;

  always_comb begin
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    state_d     = state_q;
    overflow_d  = overflow_q | (write & full);
    if (enq) tail_d = tail_q + 1'b1;
    if (ret) head_d = head_q + 1'b1;
    unique case ({enq, ret})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    unique case (state_q)
      StIdle:  if (count_q != '0) state_d = StIssue;
      StIssue: if (!mem_busy) state_d = StWait;
      StWait:  if (mem_done) state_d = StIdle;
      default: state_d = StIdle;
    endcase
    mem_write_d = (state_d == StIssue);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      mem_write_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      mem_write_q <= mem_write_d;
    end
  end

  // Storage is deliberately not reset; it is never exposed while the queue is empty.
  always_ff @(posedge clock) begin
    if (enq) begin
      len_mem[tail_q]  <= length;
      addr_mem[tail_q] <= addr;
      data_mem[tail_q] <= data;
    end
  end

  // Head is frozen from ISSUE through WAIT, so the command fields stay stable.
  always_comb begin
    mem_length = '0;
    mem_addr   = '0;
    mem_data   = '0;
    if (state_q != StIdle) begin
      mem_length = len_mem[head_q];
      mem_addr   = addr_mem[head_q];
      mem_data   = data_mem[head_q];
    end
  end

  always_comb begin
    logic [PtrW-1:0] idx;
    hazard = 1'b0;
    idx    = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = head_q + PtrW'(i);
      if ((CntW'(i) < count_q) && (addr_mem[idx][31:2] == query_addr[31:2])) hazard = 1'b1;
    end
  end

  assign busy      = (count_q >= CntW'(DEPTH - 1));
  assign empty     = (count_q == '0) && (state_q == StIdle);
  assign overflow  = overflow_q;
  assign mem_write = mem_write_q;

endmodule
